uart_alu_frontend: RTL and testbench

- Downstream consumer of the UART core's receive FIFO and producer for its transmit FIFO.
- Collects a 3-byte command frame (operand A, operand B, opcode) from the RX FIFO and presents registered operands and opcode to the combinational ALU.
- Captures the ALU result and pushes it as one byte into the TX FIFO.
- Discards partial frames after an inter-byte timeout.

---
 rtl/uart_alu_frontend.sv | 153 +++++++++++++++
 tb/tb_uart_alu_frontend.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frontend.sv
// uart_alu_frontend
//   Sits between a UART core's RX/TX FIFOs and a combinational ALU.
//   Collects a three-byte command frame (operand A, operand B, opcode) from
//   the RX FIFO, holds the operands in registers that feed the ALU, captures
//   the ALU result one cycle later and pushes it as a single byte into the
//   TX FIFO. A frame left incomplete for TIMEOUT idle cycles is dropped.
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   rx_empty     RX FIFO empty flag
//   r_data       RX FIFO head word, valid while rx_empty is low
//   rd_uart      RX FIFO pop strobe
//   tx_full      TX FIFO full flag
//   wr_uart      TX FIFO push strobe
//   w_data       byte pushed into the TX FIFO
//   alu_a        registered operand A
//   alu_b        registered operand B
//   alu_op       registered opcode
//   alu_result   combinational ALU result
//   busy         high whenever a frame is in progress (state is not WAIT_A)
//   timeout_tick one-cycle pulse when a partial frame is discarded
module uart_alu_frontend #(
  parameter int DBIT    = 8,
  parameter int OP_BITS = 6,
  parameter int TIMEOUT = 2000000,
  parameter int TO_BITS = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [DBIT-1:0]    r_data,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [DBIT-1:0]    w_data,
  output logic [DBIT-1:0]    alu_a,
  output logic [DBIT-1:0]    alu_b,
  output logic [OP_BITS-1:0] alu_op,
  input  logic [DBIT-1:0]    alu_result,
  output logic               busy,
  output logic               timeout_tick
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [DBIT-1:0]      a_q, a_d;
  logic [DBIT-1:0]      b_q, b_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [DBIT-1:0]      w_q, w_d;
  logic [TO_BITS-1:0]   cnt_q, cnt_d;

  // Next-state and strobe logic. The pop/push strobes and the timeout pulse
  // are combinational so the FIFO sees them in the same cycle the edge acts
  // on them. The idle counter defaults to zero, which covers clearing it on
  // every pop, every state change and in every state other than WAIT_B and
  // WAIT_OP. A byte that is present on the expiry cycle takes priority over
  // the timeout.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    w_d          = w_q;
    cnt_d        = '0;
    rd_uart      = 1'b0;
    wr_uart      = 1'b0;
    timeout_tick = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          a_d     = r_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          b_d     = r_data;
          state_d = WAIT_OP;
        end else if (cnt_q == TO_LAST) begin
          timeout_tick = 1'b1;
          state_d      = WAIT_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_OP: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          op_d    = r_data[OP_BITS-1:0];
          state_d = EXEC;
        end else if (cnt_q == TO_LAST) begin
          timeout_tick = 1'b1;
          state_d      = WAIT_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        // Operands have been stable in their registers for a full cycle.
        w_d     = alu_result;
        state_d = SEND;
      end
      SEND: begin
        // Wait here as long as the TX FIFO is full; w_data stays put.
        if (!tx_full) begin
          wr_uart = 1'b1;
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // All state, operand, result and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign w_data = w_q;
  assign busy   = (state_q != WAIT_A);

endmodule

// File: tb/tb_uart_alu_frontend.sv
// tb_uart_alu_frontend
//   Bench for uart_alu_frontend with a short timeout. A queue models the RX
//   FIFO, a function acts as the ALU (0x20 add, 0x22 subtract, else xor), and
//   a frame-level model predicts every output each cycle.
module tb_uart_alu_frontend;

  localparam int DBIT    = 8;
  localparam int OP_BITS = 6;
  localparam int TIMEOUT = 20;
  localparam int TO_BITS = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rx_empty = 1'b1;
  logic [DBIT-1:0]    r_data = '0;
  logic               tx_full = 1'b0;
  logic               rd_uart;
  logic               wr_uart;
  logic [DBIT-1:0]    w_data;
  logic [DBIT-1:0]    alu_a;
  logic [DBIT-1:0]    alu_b;
  logic [OP_BITS-1:0] alu_op;
  logic [DBIT-1:0]    alu_result;
  logic               busy;
  logic               timeout_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rxq[$];
  bit         pop_pending = 1'b0;

  // frame-level model
  int         m_bytes = 0;
  bit         m_exec = 1'b0;
  bit         m_pend = 1'b0;
  int         m_idle = 0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic [5:0] m_op = '0;
  logic [7:0] m_w = '0;

  // observed activity
  int         rd_count = 0;
  int         tick_count = 0;
  int         coincide = 0;
  int         last_rd_cyc = 0;
  int         last_tick_cyc = 0;
  int         rd_cycs[$];
  int         wr_cycs[$];
  logic [7:0] wr_log[$];

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_alu_frontend #(
    .DBIT(DBIT), .OP_BITS(OP_BITS), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .timeout_tick(timeout_tick)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    rxq.push_back(b);
    refresh_rx();
  endtask

  task automatic model_reset();
    m_bytes = 0; m_exec = 1'b0; m_pend = 1'b0; m_idle = 0;
    m_a = '0; m_b = '0; m_op = '0; m_w = '0;
    pop_pending = 1'b0;
  endtask

  task automatic wait_rd(input int target, input int limit);
    int k = 0;
    while (rd_count < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (rd_count < target) check_output("rd_wait_expired", 32'(rd_count), 32'(target));
  endtask

  task automatic wait_wr(input int target, input int limit);
    int k = 0;
    while (wr_log.size() < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (wr_log.size() < target) check_output("wr_wait_expired", 32'(wr_log.size()), 32'(target));
  endtask

  // RX FIFO pop happens just after the edge on which the DUT popped.
  always @(posedge clk) begin
    #1;
    if (pop_pending && !reset) begin
      pop_pending = 1'b0;
      if (rxq.size() > 0) void'(rxq.pop_front());
      refresh_rx();
    end
  end

  // Per-cycle compare against the model, then advance the model to the
  // state it must hold after the coming rising edge.
  always @(negedge clk) begin
    bit e_rd, e_wr, e_tick, e_busy;
    logic [7:0] head;
    if (!reset) begin
      e_busy = (m_bytes != 0) || m_exec || m_pend;
      e_rd   = !m_exec && !m_pend && (rxq.size() > 0);
      e_wr   = m_pend && !tx_full;
      e_tick = (m_bytes != 0) && (rxq.size() == 0) && (m_idle == TIMEOUT - 1);

      check_output("rd_uart", 32'(rd_uart), 32'(e_rd));
      check_output("wr_uart", 32'(wr_uart), 32'(e_wr));
      check_output("busy", 32'(busy), 32'(e_busy));
      check_output("timeout_tick", 32'(timeout_tick), 32'(e_tick));
      check_output("alu_a", 32'(alu_a), 32'(m_a));
      check_output("alu_b", 32'(alu_b), 32'(m_b));
      check_output("alu_op", 32'(alu_op), 32'(m_op));
      check_output("w_data", 32'(w_data), 32'(m_w));
      check_output("rd_wr_exclusive", 32'(rd_uart & wr_uart), 32'd0);

      if (rd_uart) begin
        rd_count++; last_rd_cyc = cyc; rd_cycs.push_back(cyc); pop_pending = 1'b1;
      end
      if (wr_uart) begin
        wr_log.push_back(w_data); wr_cycs.push_back(cyc);
      end
      if (timeout_tick) begin
        tick_count++; last_tick_cyc = cyc;
      end
      if (rd_uart && wr_uart) coincide++;

      if (m_exec) begin
        m_w = alu_fn(m_a, m_b, m_op);
        m_exec = 1'b0;
        m_pend = 1'b1;
      end else if (m_pend) begin
        if (e_wr) m_pend = 1'b0;
      end else if (e_rd) begin
        head = rxq[0];
        if (m_bytes == 0) m_a = head;
        else if (m_bytes == 1) m_b = head;
        else m_op = head[5:0];
        m_idle = 0;
        m_bytes++;
        if (m_bytes == 3) begin
          m_bytes = 0;
          m_exec = 1'b1;
        end
      end else if (e_tick) begin
        m_bytes = 0;
        m_idle = 0;
      end else if (m_bytes != 0) begin
        m_idle++;
      end
    end
  end

  initial begin
    int base_rd, base_wr, p;
    refresh_rx();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_rd", 32'(rd_uart), 32'd0);
    check_output("reset_wr", 32'(wr_uart), 32'd0);
    check_output("reset_tick", 32'(timeout_tick), 32'd0);
    check_output("reset_w_data", 32'(w_data), 32'd0);
    check_output("reset_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // reset in the middle of a frame
    apply_stimulus(8'h05);
    wait_rd(1, 20);
    #2;
    check_output("midframe_alu_a_before", 32'(alu_a), 32'h05);
    check_output("midframe_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check_output("midframe_busy", 32'(busy), 32'd0);
    check_output("midframe_alu_a", 32'(alu_a), 32'd0);
    check_output("midframe_rd", 32'(rd_uart), 32'd0);
    check_output("midframe_wr", 32'(wr_uart), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // single frame: 5 + 3
    base_rd = rd_count;
    apply_stimulus(8'h05); apply_stimulus(8'h03); apply_stimulus(8'h20);
    wait_wr(1, 50);
    check_output("single_pops", 32'(rd_count - base_rd), 32'd3);
    check_output("single_alu_a", 32'(alu_a), 32'h05);
    check_output("single_alu_b", 32'(alu_b), 32'h03);
    check_output("single_alu_op", 32'(alu_op), 32'h20);
    check_output("single_result", 32'(wr_log[0]), 32'h08);
    check_output("single_latency", 32'(wr_cycs[0] - last_rd_cyc), 32'd2);
    repeat (2) @(posedge clk);

    // TX back-pressure
    #2;
    tx_full = 1'b1;
    base_rd = rd_count;
    apply_stimulus(8'h05); apply_stimulus(8'h03); apply_stimulus(8'h20);
    wait_rd(base_rd + 3, 50);
    repeat (52) @(posedge clk);
    #2;
    check_output("bp_no_write", 32'(wr_log.size()), 32'd1);
    check_output("bp_w_data", 32'(w_data), 32'h08);
    check_output("bp_busy", 32'(busy), 32'd1);
    tx_full = 1'b0;
    wait_wr(2, 20);
    check_output("bp_result", 32'(wr_log[1]), 32'h08);
    @(posedge clk); #2;
    check_output("bp_idle", 32'(busy), 32'd0);

    // timeout with only A delivered
    base_rd = rd_count;
    apply_stimulus(8'h11);
    wait_rd(base_rd + 1, 20);
    p = last_rd_cyc;
    begin
      int k = 0;
      while (tick_count < 1 && k < 60) begin
        @(posedge clk);
        k++;
      end
    end
    check_output("to_tick_count", 32'(tick_count), 32'd1);
    check_output("to_tick_delay", 32'(last_tick_cyc - p), 32'd20);
    repeat (3) @(posedge clk);
    #2;
    check_output("to_idle", 32'(busy), 32'd0);
    check_output("to_single_pulse", 32'(tick_count), 32'd1);
    apply_stimulus(8'h02); apply_stimulus(8'h02); apply_stimulus(8'h20);
    wait_wr(3, 50);
    check_output("to_next_result", 32'(wr_log[2]), 32'h04);
    repeat (2) @(posedge clk);

    // B byte arrives exactly on the expiry cycle
    #2;
    base_rd = rd_count;
    apply_stimulus(8'h30);
    wait_rd(base_rd + 1, 20);
    p = last_rd_cyc;
    repeat (19) @(posedge clk);
    #2;
    apply_stimulus(8'h0C); apply_stimulus(8'h20);
    wait_wr(4, 50);
    check_output("race_b_pop_cycle", 32'(rd_cycs[base_rd + 1] - p), 32'd20);
    check_output("race_no_tick", 32'(tick_count), 32'd1);
    check_output("race_result", 32'(wr_log[3]), 32'h3C);
    repeat (2) @(posedge clk);

    // two frames preloaded back to back
    #2;
    base_rd = rd_count;
    base_wr = wr_log.size();
    apply_stimulus(8'hFF); apply_stimulus(8'h01); apply_stimulus(8'h20);
    apply_stimulus(8'h0A); apply_stimulus(8'h04); apply_stimulus(8'h22);
    wait_wr(base_wr + 2, 100);
    check_output("b2b_first", 32'(wr_log[base_wr]), 32'h00);
    check_output("b2b_second", 32'(wr_log[base_wr + 1]), 32'h06);
    check_output("b2b_pops", 32'(rd_count - base_rd), 32'd6);
    check_output("b2b_next_a_pop", 32'(rd_cycs[base_rd + 3] - wr_cycs[base_wr]), 32'd1);
    check_output("b2b_no_coincide", 32'(coincide), 32'd0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
